// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS multicycle controller: FSM states, ALU functions,
// opcode/funct values and the datapath mux select codes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_SH  = 4'd3,
    S_EXEC_I   = 4'd4,
    S_WB_R     = 4'd5,
    S_WB_I     = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_ACC  = 4'd8,
    S_WB_MEM   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_FAULT    = 4'd12
  } state_t;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_NOR  = 4'h5;
  localparam logic [3:0] ALU_SLT  = 4'h6;
  localparam logic [3:0] ALU_SLTU = 4'h7;
  localparam logic [3:0] ALU_SLL  = 4'h8;
  localparam logic [3:0] ALU_SRL  = 4'h9;
  localparam logic [3:0] ALU_SRA  = 4'hA;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [1:0] SSE_SEXT     = 2'b00;
  localparam logic [1:0] SSE_SEXT_SH2 = 2'b01;
  localparam logic [1:0] SSE_IMM26    = 2'b10;
  localparam logic [1:0] SSE_SHAMT    = 2'b11;

  localparam logic [1:0] ALUB_REG  = 2'b00;
  localparam logic [1:0] ALUB_FOUR = 2'b01;
  localparam logic [1:0] ALUB_EXT  = 2'b10;

  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_TGT  = 2'b01;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;

endpackage

// File: rtl/mips_alu_decode.sv
// Funct-field decode for the R-type execute states: ALU function, legality and
// whether the instruction is a constant shift (shamt operand).
module mips_alu_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [3:0] o_alu_op,
  output logic       o_legal,
  output logic       o_shift
);

  always_comb begin
    o_alu_op = ALU_ADD;
    o_legal  = 1'b1;
    o_shift  = 1'b0;
    case (i_funct)
      FN_SLL:          begin o_alu_op = ALU_SLL; o_shift = 1'b1; end
      FN_SRL:          begin o_alu_op = ALU_SRL; o_shift = 1'b1; end
      FN_SRA:          begin o_alu_op = ALU_SRA; o_shift = 1'b1; end
      FN_ADD, FN_ADDU: o_alu_op = ALU_ADD;
      FN_SUB, FN_SUBU: o_alu_op = ALU_SUB;
      FN_AND:          o_alu_op = ALU_AND;
      FN_OR:           o_alu_op = ALU_OR;
      FN_XOR:          o_alu_op = ALU_XOR;
      FN_NOR:          o_alu_op = ALU_NOR;
      FN_SLT:          o_alu_op = ALU_SLT;
      FN_SLTU:         o_alu_op = ALU_SLTU;
      default:         o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback and
// drives every datapath select, with a memory-wait watchdog that parks in FAULT.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  input  logic       i_alu_zero,
  input  logic       i_mem_ready,
  output logic       o_mem_req,
  output logic       o_mem_we,
  output logic       o_ir_ld,
  output logic       o_pc_ld,
  output logic [1:0] o_pc_src,
  output logic       o_tgt_ld,
  output logic       o_mdr_ld,
  output logic       o_rf_we,
  output logic       o_rf_dst,
  output logic       o_rf_src,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [3:0] o_alu_op,
  output logic [1:0] o_sse,
  output logic       o_fault,
  output logic [3:0] o_state_dbg
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  state_t          r_state;
  state_t          w_next_state;
  logic [CW-1:0]   r_wait_cnt;
  logic [3:0]      w_fn_alu_op;
  logic            w_fn_legal;
  logic            w_fn_shift;
  logic            w_mem_state;
  logic            w_timeout;

  mips_alu_decode u_alu_decode (
    .i_funct  (i_funct),
    .o_alu_op (w_fn_alu_op),
    .o_legal  (w_fn_legal),
    .o_shift  (w_fn_shift)
  );

  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM_ACC);
  // Last allowed wait cycle; mem_ready in this same cycle still completes the access.
  assign w_timeout   = (r_wait_cnt == CW'(MEM_TIMEOUT - 1));
  assign o_state_dbg = r_state;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if ((w_next_state != r_state) || !w_mem_state) begin
        r_wait_cnt <= '0;
      end else begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    o_mem_req    = 1'b0;
    o_mem_we     = 1'b0;
    o_ir_ld      = 1'b0;
    o_pc_ld      = 1'b0;
    o_pc_src     = PCSRC_ALU;
    o_tgt_ld     = 1'b0;
    o_mdr_ld     = 1'b0;
    o_rf_we      = 1'b0;
    o_rf_dst     = 1'b0;
    o_rf_src     = 1'b0;
    o_alu_src_a  = 1'b0;
    o_alu_src_b  = ALUB_REG;
    o_alu_op     = ALU_ADD;
    o_sse        = SSE_SEXT;
    o_fault      = 1'b0;
    // While reset is held every strobe stays low, so an in-flight request drops at once.
    if (!i_reset) begin
      case (r_state)
        S_FETCH: begin
          o_mem_req   = 1'b1;
          o_alu_src_b = ALUB_FOUR;
          if (i_mem_ready) begin
            o_ir_ld      = 1'b1;
            o_pc_ld      = 1'b1;
            w_next_state = S_DECODE;
          end else if (w_timeout) begin
            w_next_state = S_FAULT;
          end
        end
        S_DECODE: begin
          o_alu_src_b = ALUB_EXT;
          o_sse       = SSE_SEXT_SH2;
          o_tgt_ld    = 1'b1;
          case (i_opcode)
            OP_RTYPE:     w_next_state = !w_fn_legal ? S_FAULT :
                                         (w_fn_shift ? S_EXEC_SH : S_EXEC_R);
            OP_ADDIU:     w_next_state = S_EXEC_I;
            OP_LW, OP_SW: w_next_state = S_MEM_ADDR;
            OP_BEQ, OP_BNE: w_next_state = S_BRANCH;
            OP_J:         w_next_state = S_JUMP;
            default:      w_next_state = S_FAULT;
          endcase
        end
        S_EXEC_R: begin
          o_alu_src_a  = 1'b1;
          o_alu_src_b  = ALUB_REG;
          o_alu_op     = w_fn_alu_op;
          w_next_state = S_WB_R;
        end
        S_EXEC_SH: begin
          o_alu_src_b  = ALUB_EXT;
          o_sse        = SSE_SHAMT;
          o_alu_op     = w_fn_alu_op;
          w_next_state = S_WB_R;
        end
        S_EXEC_I, S_MEM_ADDR: begin
          o_alu_src_a  = 1'b1;
          o_alu_src_b  = ALUB_EXT;
          o_sse        = SSE_SEXT;
          w_next_state = (r_state == S_EXEC_I) ? S_WB_I : S_MEM_ACC;
        end
        S_WB_R: begin
          o_rf_we      = 1'b1;
          o_rf_dst     = 1'b1;
          w_next_state = S_FETCH;
        end
        S_WB_I: begin
          o_rf_we      = 1'b1;
          w_next_state = S_FETCH;
        end
        S_MEM_ACC: begin
          o_mem_req = 1'b1;
          o_mem_we  = (i_opcode == OP_SW);
          if (i_mem_ready) begin
            o_mdr_ld     = (i_opcode != OP_SW);
            w_next_state = (i_opcode == OP_SW) ? S_FETCH : S_WB_MEM;
          end else if (w_timeout) begin
            w_next_state = S_FAULT;
          end
        end
        S_WB_MEM: begin
          o_rf_we      = 1'b1;
          o_rf_src     = 1'b1;
          w_next_state = S_FETCH;
        end
        S_BRANCH: begin
          o_alu_src_a  = 1'b1;
          o_alu_src_b  = ALUB_REG;
          o_alu_op     = ALU_SUB;
          o_pc_src     = PCSRC_TGT;
          o_pc_ld      = (i_opcode == OP_BEQ) ? i_alu_zero : !i_alu_zero;
          w_next_state = S_FETCH;
        end
        S_JUMP: begin
          o_sse        = SSE_IMM26;
          o_pc_src     = PCSRC_JUMP;
          o_pc_ld      = 1'b1;
          w_next_state = S_FETCH;
        end
        S_FAULT: begin
          o_fault = 1'b1;
        end
        default: begin
          w_next_state = S_FAULT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized bench for mips_multicycle_ctrl: an instruction-level model expands each
// instruction into its expected per-cycle state and output trace.
module tb_mips_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       alu_zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, ir_ld, pc_ld, tgt_ld, mdr_ld;
  logic       rf_we, rf_dst, rf_src, alu_src_a, fault;
  logic [1:0] pc_src, alu_src_b, sse;
  logic [3:0] alu_op, state_dbg;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .i_clk(clk), .i_reset(reset), .i_opcode(opcode), .i_funct(funct),
    .i_alu_zero(alu_zero), .i_mem_ready(mem_ready),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_ir_ld(ir_ld), .o_pc_ld(pc_ld),
    .o_pc_src(pc_src), .o_tgt_ld(tgt_ld), .o_mdr_ld(mdr_ld), .o_rf_we(rf_we),
    .o_rf_dst(rf_dst), .o_rf_src(rf_src), .o_alu_src_a(alu_src_a),
    .o_alu_src_b(alu_src_b), .o_alu_op(alu_op), .o_sse(sse), .o_fault(fault),
    .o_state_dbg(state_dbg)
  );

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       ir_ld;
    logic       pc_ld;
    logic [1:0] pc_src;
    logic       tgt_ld;
    logic       mdr_ld;
    logic       rf_we;
    logic       rf_dst;
    logic       rf_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic [1:0] sse;
    logic       fault;
  } ov_t;

  typedef struct packed {
    logic [3:0] st;
    logic       rdy;
    logic       z;
    ov_t        o;
  } rec_t;

  typedef enum {K_R, K_SH, K_I, K_LW, K_SW, K_BR, K_J, K_BAD} kind_t;

  rec_t       q[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         n_instr = 0;
  logic [5:0] fn_tab [13] = '{6'h00, 6'h02, 6'h03, 6'h20, 6'h21, 6'h22, 6'h23,
                              6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ov_t observe();
    ov_t o;
    o.mem_req = mem_req;   o.mem_we = mem_we;       o.ir_ld = ir_ld;
    o.pc_ld = pc_ld;       o.pc_src = pc_src;       o.tgt_ld = tgt_ld;
    o.mdr_ld = mdr_ld;     o.rf_we = rf_we;         o.rf_dst = rf_dst;
    o.rf_src = rf_src;     o.alu_src_a = alu_src_a; o.alu_src_b = alu_src_b;
    o.alu_op = alu_op;     o.sse = sse;             o.fault = fault;
    return o;
  endfunction

  function automatic kind_t kind_of(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: begin
        if (fn inside {6'h00, 6'h02, 6'h03}) return K_SH;
        if (fn inside {[6'h20:6'h27], 6'h2A, 6'h2B}) return K_R;
        return K_BAD;
      end
      6'h09:        return K_I;
      6'h23:        return K_LW;
      6'h2B:        return K_SW;
      6'h04, 6'h05: return K_BR;
      6'h02:        return K_J;
      default:      return K_BAD;
    endcase
  endfunction

  function automatic logic [3:0] ref_aluop(input logic [5:0] fn);
    case (fn)
      6'h00: return ALU_SLL;
      6'h02: return ALU_SRL;
      6'h03: return ALU_SRA;
      6'h22, 6'h23: return ALU_SUB;
      6'h24: return ALU_AND;
      6'h25: return ALU_OR;
      6'h26: return ALU_XOR;
      6'h27: return ALU_NOR;
      6'h2A: return ALU_SLT;
      6'h2B: return ALU_SLTU;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  task automatic push(input state_t st, input logic rdy, input logic z, input ov_t o);
    rec_t r;
    r.st = st; r.rdy = rdy; r.z = z; r.o = o;
    q.push_back(r);
  endtask

  // A memory wait: `waits` idle cycles then completion, unless the watchdog expires first.
  task automatic mem_phase(input state_t st, input int waits, input ov_t base,
                           input ov_t done, output bit faulted);
    int w;
    w = (waits < TO) ? waits : TO;
    for (int k = 0; k < w; k++) push(st, 1'b0, rb(), base);
    faulted = (waits >= TO);
    if (!faulted) push(st, 1'b1, rb(), done);
  endtask

  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int wf, input int wm, output bit faulted);
    ov_t   o, d;
    kind_t k;
    k = kind_of(op, fn);
    q.delete();
    o = '0; o.mem_req = 1'b1; o.alu_src_b = ALUB_FOUR; o.alu_op = ALU_ADD;
    d = o;  d.ir_ld = 1'b1; d.pc_ld = 1'b1; d.pc_src = PCSRC_ALU;
    mem_phase(S_FETCH, wf, o, d, faulted);
    if (!faulted) begin
      o = '0; o.alu_src_b = ALUB_EXT; o.sse = SSE_SEXT_SH2; o.tgt_ld = 1'b1;
      push(S_DECODE, rb(), rb(), o);
      case (k)
        K_R, K_SH: begin
          o = '0; o.alu_op = ref_aluop(fn);
          if (k == K_R) begin
            o.alu_src_a = 1'b1; o.alu_src_b = ALUB_REG;
            push(S_EXEC_R, rb(), rb(), o);
          end else begin
            o.alu_src_b = ALUB_EXT; o.sse = SSE_SHAMT;
            push(S_EXEC_SH, rb(), rb(), o);
          end
          o = '0; o.rf_we = 1'b1; o.rf_dst = 1'b1;
          push(S_WB_R, rb(), rb(), o);
        end
        K_I: begin
          o = '0; o.alu_src_a = 1'b1; o.alu_src_b = ALUB_EXT; o.sse = SSE_SEXT;
          push(S_EXEC_I, rb(), rb(), o);
          o = '0; o.rf_we = 1'b1;
          push(S_WB_I, rb(), rb(), o);
        end
        K_LW, K_SW: begin
          o = '0; o.alu_src_a = 1'b1; o.alu_src_b = ALUB_EXT; o.sse = SSE_SEXT;
          push(S_MEM_ADDR, rb(), rb(), o);
          o = '0; o.mem_req = 1'b1; o.mem_we = (k == K_SW);
          d = o;  d.mdr_ld = (k == K_LW);
          mem_phase(S_MEM_ACC, wm, o, d, faulted);
          if (!faulted && k == K_LW) begin
            o = '0; o.rf_we = 1'b1; o.rf_src = 1'b1;
            push(S_WB_MEM, rb(), rb(), o);
          end
        end
        K_BR: begin
          o = '0; o.alu_src_a = 1'b1; o.alu_src_b = ALUB_REG; o.alu_op = ALU_SUB;
          o.pc_src = PCSRC_TGT; o.pc_ld = (op == OP_BEQ) ? z : !z;
          push(S_BRANCH, rb(), z, o);
        end
        K_J: begin
          o = '0; o.sse = SSE_IMM26; o.pc_src = PCSRC_JUMP; o.pc_ld = 1'b1;
          push(S_JUMP, rb(), rb(), o);
        end
        default: faulted = 1'b1;
      endcase
    end
    if (faulted) begin
      o = '0; o.fault = 1'b1;
      for (int i = 0; i < 3; i++) push(S_FAULT, rb(), rb(), o);
    end
  endtask

  // Entered and left at a falling edge; inputs change there and outputs are sampled 1ns later.
  task automatic run(input logic [5:0] op, input logic [5:0] fn, input int lim);
    int c;
    opcode = op;
    funct  = fn;
    for (c = 0; c < q.size() && c < lim; c++) begin
      mem_ready = q[c].rdy;
      alu_zero  = q[c].z;
      #1;
      chk($sformatf("i%0d c%0d state", n_instr, c), 32'(state_dbg), 32'(q[c].st));
      chk($sformatf("i%0d c%0d outs", n_instr, c), 32'(observe()), 32'(q[c].o));
      @(negedge clk);
    end
    $display("instr %0d op=%02h fn=%02h cycles=%0d", n_instr, op, fn, c);
    n_instr++;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    mem_ready = rb();
    alu_zero  = rb();
    @(posedge clk);
    #1;
    chk($sformatf("i%0d reset state", n_instr), 32'(state_dbg), 32'(S_FETCH));
    chk($sformatf("i%0d reset outs", n_instr), 32'(observe()), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int wf, input int wm);
    bit f;
    build(op, fn, z, wf, wm, f);
    run(op, fn, 1000);
    if (f) do_reset();
  endtask

  function automatic int rw();
    int r;
    r = int'($urandom_range(0, 39));
    if (r < 28) return 0;
    if (r < 36) return r - 27;
    if (r < 39) return TO - 1;
    return TO;
  endfunction

  initial begin
    logic [5:0] op, fn;
    bit         f;
    @(negedge clk);
    do_reset();

    instr(OP_ADDIU, 6'h15, 1'b0, 0, 0);
    instr(OP_LW, 6'h3C, 1'b0, 0, 3);
    instr(OP_BEQ, 6'h00, 1'b1, 0, 0);
    instr(OP_BNE, 6'h00, 1'b1, 0, 0);
    instr(OP_RTYPE, FN_SLL, 1'b0, 0, 0);
    instr(OP_J, 6'h11, 1'b0, 0, 0);
    instr(OP_RTYPE, FN_SUB, 1'b0, 0, 0);
    instr(OP_SW, 6'h01, 1'b0, TO - 1, TO - 1);
    instr(OP_ADDIU, 6'h00, 1'b0, TO, 0);
    instr(6'h3F, 6'h00, 1'b0, 0, 0);
    instr(OP_RTYPE, 6'h3E, 1'b0, 0, 0);
    instr(OP_LW, 6'h00, 1'b0, 0, TO);

    // Reset lands while a load is still waiting in MEM_ACC.
    build(OP_LW, 6'h00, 1'b0, 0, 6, f);
    run(OP_LW, 6'h00, 5);
    do_reset();

    for (int i = 0; i < 120; i++) begin
      case ($urandom_range(0, 8))
        0, 1: op = OP_RTYPE;
        2: op = OP_ADDIU;
        3: op = OP_LW;
        4: op = OP_SW;
        5: op = OP_BEQ;
        6: op = OP_BNE;
        7: op = OP_J;
        default: op = 6'($urandom);
      endcase
      fn = ($urandom_range(0, 3) != 0) ? fn_tab[$urandom_range(0, 12)] : 6'($urandom);
      instr(op, fn, rb(), rw(), rw());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
